// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Copies a sprite from a combinational sprite ROM into the framebuffer
//   at (x_pos, y_pos). Pixels equal to KEY_COLOR are treated as
//   transparent. Pixels that land off-screen are clipped. Optional
//   horizontal mirroring is supported.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   start                 one-cycle draw request (only honoured while idle)
//   x_pos, y_pos, flip    placement and mirror flag, latched on start
//   rom_pixel             row-major pixel index presented to the ROM
//   rom_color             ROM colour for rom_pixel (same cycle)
//   rom_width/rom_height  sprite size minus one, latched on start
//   fb_we/fb_addr/fb_data registered framebuffer write, held until fb_ready
//   fb_ready              framebuffer accepts the write this cycle
//   busy                  high whenever a draw is in progress
//   done                  one-cycle pulse when the draw has completed
module sprite_blitter #(
    parameter int          SCREEN_W  = 320,
    parameter int          SCREEN_H  = 240,
    parameter logic [15:0] KEY_COLOR = 16'hFFFF,
    parameter int          FB_AW     = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [9:0]       x_pos,
    input  logic [9:0]       y_pos,
    input  logic             flip,
    output logic [16:0]      rom_pixel,
    input  logic [15:0]      rom_color,
    input  logic [8:0]       rom_width,
    input  logic [8:0]       rom_height,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [15:0]      fb_data,
    input  logic             fb_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [10:0] SW11 = 11'(SCREEN_W);
    localparam logic [10:0] SH11 = 11'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nxt;

    logic [9:0]  x_r, y_r;
    logic        flip_r;
    logic [8:0]  w_r, h_r;
    logic [8:0]  col, row;
    logic [16:0] row_base;

    logic [8:0]  src_col;
    logic [10:0] sx, sy;
    logic        writable;
    logic        slot_free;
    logic        last_px;

    assign slot_free = !fb_we || fb_ready;
    assign last_px   = (col == w_r) && (row == h_r);

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start)                state_nxt = RUN;
            RUN:   if (slot_free && last_px) state_nxt = DRAIN;
            DRAIN: if (slot_free)            state_nxt = DONE;
            DONE:                            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Output / address-generation logic
    always_comb begin
        src_col   = flip_r ? (w_r - col) : col;
        rom_pixel = row_base + {8'd0, src_col};
        sx        = {1'b0, x_r} + {2'b0, col};
        sy        = {1'b0, y_r} + {2'b0, row};
        writable  = (rom_color != KEY_COLOR) && (sx < SW11) && (sy < SH11);
        busy      = (state != IDLE);
    end

    // Datapath: latched request, traversal counters and the write slot
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r      <= '0;
            y_r      <= '0;
            flip_r   <= 1'b0;
            w_r      <= '0;
            h_r      <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            done     <= 1'b0;
        end else begin
            // done is a registered flag of the DONE state, so it appears in
            // the cycle after DONE, when busy has already dropped.
            done <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_r      <= x_pos;
                        y_r      <= y_pos;
                        flip_r   <= flip;
                        w_r      <= rom_width;
                        h_r      <= rom_height;
                        col      <= '0;
                        row      <= '0;
                        row_base <= '0;
                    end
                end
                RUN: begin
                    if (slot_free) begin
                        fb_we   <= writable;
                        fb_addr <= FB_AW'(32'(sy) * 32'(SCREEN_W) + 32'(sx));
                        fb_data <= rom_color;
                        if (col == w_r) begin
                            col      <= '0;
                            row      <= row + 9'd1;
                            row_base <= row_base + {8'd0, w_r} + 17'd1;
                        end else begin
                            col <= col + 9'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (slot_free)
                        fb_we <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reads a sprite from a combinational sprite ROM and writes its opaque pixels into the framebuffer at a requested screen position.
- The ROM presents a 17-bit row-major pixel index, with 0 at top-left, and returns 16-bit RGB565 colour plus 0-indexed width and height.
- The block sits between the game/sprite controller and the framebuffer write port.
- It supports a transparency key, horizontal mirroring (e.g. left/right walk frames from one ROM) and clipping at the screen edge.

Parameters:
- SCREEN_W, 320, framebuffer width in pixels.
- SCREEN_H, 240, framebuffer height in pixels.
- KEY_COLOR, 16'hFFFF, transparent colour; pixels equal to it are not written.
- FB_AW, 17, framebuffer address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to draw; sampled only in IDLE.
- x_pos  in  10  screen column of the sprite's top-left pixel.
- y_pos  in  10  screen row of the sprite's top-left pixel.
- flip  in  1  1 = mirror horizontally.
- rom_pixel  out  17  pixel index presented to the sprite ROM.
- rom_color  in  16  ROM colour for rom_pixel, combinational, same cycle.
- rom_width  in  9  sprite width minus 1.
- rom_height  in  9  sprite height minus 1.
- fb_we  out  1  framebuffer write valid.
- fb_addr  out  FB_AW  write address = row*SCREEN_W + col.
- fb_data  out  16  write colour.
- fb_ready  in  1  framebuffer accepts the write when fb_we && fb_ready.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the draw completes.

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-draw):
  - State becomes IDLE.
  - fb_we=0, fb_addr=0, fb_data=0, rom_pixel=0, busy=0, done=0.
  - All counters are cleared; no further writes are issued.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, latch x_pos, y_pos, flip, rom_width (W) and rom_height (H).
  - Clear col, row and row_base to 0, then go to RUN.
  - start is ignored in every other state.
- Source column and ROM index:
  - src_col = flip ? W-col : col.
  - rom_pixel = row_base + src_col, combinational from registers.
  - row_base advances by W+1 at each row end; no multiplier on the ROM side.
- Screen coordinates:
  - sx = x + col and sy = y + row, computed 11 bits wide.
  - A pixel is writable when rom_color != KEY_COLOR, sx < SCREEN_W and sy < SCREEN_H.
  - Clipped pixels are skipped; there is no wrap-around.
- Output slot: fb_we/fb_addr/fb_data are registered, and a slot is free when !fb_we || fb_ready.
- RUN, each cycle the slot is free:
  - fb_we <= writable, fb_addr <= sy*SCREEN_W + sx, fb_data <= rom_color.
  - Then advance: if col==W, col<=0, row<=row+1, row_base<=row_base+W+1; otherwise col<=col+1.
  - After the pixel with col==W and row==H, go to DRAIN.
- RUN, slot not free (backpressure): counters, rom_pixel and the fb_* outputs hold stable.
  - fb_we stays high until accepted; it never drops without acceptance.
- DRAIN:
  - When the slot is free, clear fb_we and go to DONE.
  - The last write is always accepted before done.
- DONE: done=1 for exactly one cycle, then IDLE; busy is 0 on the cycle after DONE.
- Timing:
  - start at cycle 0 gives RUN at cycle 1 and the first fb_we at cycle 2.
  - An unstalled (W+1)*(H+1)-pixel sprite pulses done at cycle (W+1)*(H+1)+3.
- Arithmetic:
  - rom_pixel is 17 bits; W,H ≤ 511 is legal, but the product must fit in 17 bits (caller's responsibility).
  - fb_addr is truncated to FB_AW.
- Fully transparent or fully clipped sprites still traverse every pixel, issue no writes and still pulse done.

Test Plan:
- W=2,H=1 (3x2 sprite), all opaque colours 0x0001..0x0006, start at (10,5), flip=0, fb_ready=1:
  - Writes in order to addresses 1610,1611,1612,1930,1931,1932 with data 1..6.
  - done pulses at cycle 9.
- Same sprite with flip=1: rom_pixel sequence is 2,1,0,5,4,3; the data at address 1610 is 0x0003.
- Pixels 0x0002 and 0x0005 set to 16'hFFFF: only 4 writes occur; addresses 1611 and 1931 are never written.
- Start at (319,239) with the 3x2 sprite:
  - Exactly 1 write, addr 76799, data of pixel 0.
  - done still pulses; no address ≥ 76800 appears.
- fb_ready=0 for 3 cycles while fb_we=1 on the first pixel:
  - fb_addr, fb_data and rom_pixel hold stable.
  - The write sequence is unchanged; done is delayed by 3 cycles.
- Control edge cases:
  - A second start while busy is ignored.
  - reset asserted mid-RUN gives fb_we=0, busy=0, done=0 next cycle.
  - A fresh start afterwards redraws from pixel 0.
